// File: rtl/atoi_rdx_if.sv
// atoi_rdx_if -- request/result and byte-memory bus of the radix number parser.
//   start/base/tib : conversion request (host -> parser)
//   ai / ch        : byte read address (parser -> RAM), RAM data one cycle later
//   bsy/done       : busy level and one-cycle completion pulse
//   vo/err/ovf/ea  : signed result, syntax error, overflow, terminator address
// slave  : the parser side.
// master : the host plus RAM side.
interface atoi_rdx_if #(
    parameter int ASZ = 17,
    parameter int DSZ = 32
);
    logic           start;
    logic [5:0]     base;
    logic [ASZ-1:0] tib;
    logic [ASZ-1:0] ai;
    logic [7:0]     ch;
    logic           bsy;
    logic           done;
    logic [DSZ-1:0] vo;
    logic           err;
    logic           ovf;
    logic [ASZ-1:0] ea;

    modport slave  (input  start, base, tib, ch,
                    output ai, bsy, done, vo, err, ovf, ea);
    modport master (output start, base, tib, ch,
                    input  ai, bsy, done, vo, err, ovf, ea);
endinterface

// File: rtl/atoi_rdx.sv
// atoi_rdx -- converts a character string in byte memory to a signed DSZ-bit
// integer in any radix 2..36. Skips leading spaces, takes one optional sign,
// then accumulates one digit per cycle until a non-digit or MAXLEN characters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : atoi_rdx_if.slave (request, memory bus, result)
module atoi_rdx #(
    parameter int ASZ    = 17,
    parameter int DSZ    = 32,
    parameter int MAXLEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    atoi_rdx_if.slave  bus
);
    localparam int PW = DSZ + 6;
    localparam int CW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {IDLE, LEAD, ACC, DONE} st_t;

    st_t            st;
    logic [ASZ-1:0] ai_q;
    logic [5:0]     rdx;
    logic [DSZ-1:0] mag;
    logic           neg;
    logic           seen;
    logic [CW-1:0]  cnt;

    logic [5:0]     dval;
    logic           dok;
    logic [PW-1:0]  prod;
    logic           scan, acc, sgn, spc, stop, cap;
    logic [DSZ-1:0] mag_f;
    logic           neg_f, seen_f, ovf_f;
    logic [CW-1:0]  cnt_nx;

    // The start cycle drives tib straight onto the bus so the first character
    // arrives in the first scan cycle; afterwards ai runs one ahead of ch.
    assign bus.ai = (st == IDLE && bus.start) ? bus.tib : ai_q;

    // Digit decode; 63 marks a non-digit and never passes the base compare.
    always_comb begin
        dval = 6'd63;
        if (bus.ch >= 8'h30 && bus.ch <= 8'h39)      dval = 6'(bus.ch - 8'h30);
        else if (bus.ch >= 8'h61 && bus.ch <= 8'h7a) dval = 6'(bus.ch - 8'd87);
        else if (bus.ch >= 8'h41 && bus.ch <= 8'h5a) dval = 6'(bus.ch - 8'd55);
    end

    assign dok  = dval < rdx;
    // Widened product: 36*(2^DSZ-1)+35 still fits in DSZ+6 bits.
    assign prod = PW'(mag) * PW'(rdx) + PW'(dval);

    always_comb begin
        scan   = (st == LEAD) || (st == ACC);
        acc    = scan && dok;
        sgn    = (st == LEAD) && (bus.ch == 8'h2d || bus.ch == 8'h2b);
        spc    = (st == LEAD) && (bus.ch == 8'h20);
        stop   = scan && !acc && !sgn && !spc;
        cnt_nx = cnt + 1'b1;
        // Length cap: the character just consumed counts, so termination
        // happens in the same cycle and ea points past it.
        cap    = scan && !stop && (cnt_nx == CW'(MAXLEN));
        mag_f  = acc ? prod[DSZ-1:0] : mag;
        neg_f  = neg | ((st == LEAD) && bus.ch == 8'h2d);
        seen_f = seen | acc;
        ovf_f  = bus.ovf | (acc & (|prod[PW-1:DSZ]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            ai_q     <= '0;
            rdx      <= '0;
            mag      <= '0;
            neg      <= 1'b0;
            seen     <= 1'b0;
            cnt      <= '0;
            bus.bsy  <= 1'b0;
            bus.done <= 1'b0;
            bus.vo   <= '0;
            bus.err  <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.ea   <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.start) begin
                        bus.vo  <= '0;
                        bus.ovf <= 1'b0;
                        if (bus.base >= 6'd2 && bus.base <= 6'd36) begin
                            rdx     <= bus.base;
                            ai_q    <= bus.tib + 1'b1;
                            bus.err <= 1'b0;
                            neg     <= 1'b0;
                            seen    <= 1'b0;
                            mag     <= '0;
                            cnt     <= '0;
                            bus.bsy <= 1'b1;
                            st      <= LEAD;
                        end else begin
                            bus.err  <= 1'b1;
                            bus.ea   <= bus.tib;
                            bus.done <= 1'b1;
                            st       <= DONE;
                        end
                    end
                end
                LEAD, ACC: begin
                    ai_q    <= ai_q + 1'b1;
                    cnt     <= cnt_nx;
                    mag     <= mag_f;
                    neg     <= neg_f;
                    seen    <= seen_f;
                    bus.ovf <= ovf_f;
                    if (stop || cap) begin
                        bus.vo   <= neg_f ? -mag_f : mag_f;
                        bus.err  <= !seen_f;
                        bus.ea   <= stop ? ai_q - 1'b1 : ai_q;
                        bus.bsy  <= 1'b0;
                        bus.done <= 1'b1;
                        st       <= DONE;
                    end else if (!spc) begin
                        st <= ACC;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    st       <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/atoi_rdx.md
Name: atoi_rdx

Overview:
- Parametrised successor to the eForthChip number parser: converts a character string in byte memory into a signed DSZ-bit integer.
- Acts as its own memory-bus master. It issues one byte address per cycle and consumes one character per cycle; a synchronous RAM returns data one cycle after the address.
- Adds the following over the previous parser: any radix 2..36, leading-space skip, '+' sign, overflow and syntax-error flags, end-address report for >IN update, bounded scan length, and an asynchronous reset.
- Sits beside the inner interpreter's number-conversion path.

Parameters:
- ASZ, 17, byte address width.
- DSZ, 32, result width.
- MAXLEN, 64, maximum characters scanned per conversion, counting spaces and sign.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request; sampled only in IDLE.
- base, in, 6, radix; latched at start.
- tib, in, ASZ, string start address; latched at start.
- ai, out, ASZ, memory read address.
- ch, in, 8, memory data; holds mem[ai] from the previous cycle.
- bsy, out, 1, conversion in progress.
- done, out, 1, one-cycle completion pulse.
- vo, out, DSZ, signed result.
- err, out, 1, no digit converted, or bad base.
- ovf, out, 1, magnitude exceeded 2^DSZ-1.
- ea, out, ASZ, address of the terminating character.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; ai=0, bsy=0, done=0, vo=0, err=0, ovf=0, ea=0; internal magnitude, neg flag and length counter cleared. Reset asserted mid-conversion aborts it with no done pulse.
- States: IDLE, LEAD, ACC, DONE.
- IDLE:
  - start=1 with base in 2..36: latch base, ai<=tib, clear vo/err/ovf/neg/magnitude/counter, bsy<=1, go LEAD.
  - start=1 with base<2 or base>36: go DONE with err=1, ea=tib.
  - start while bsy is ignored.
- Digit decode (combinational on ch): '0'..'9' -> 0..9; 'a'..'z' and 'A'..'Z' -> 10..35; anything else invalid. A digit is valid only if its value < base.
- LEAD and ACC, every cycle: ch corresponds to address ai-1; ai<=ai+1; counter increments.
- LEAD:
  - ' ': stay in LEAD.
  - '-': neg<=1, go ACC.
  - '+': go ACC.
  - valid digit: accumulate, go ACC.
  - anything else: terminate.
- ACC:
  - valid digit: accumulate, stay in ACC.
  - anything else (NUL, space, punctuation, out-of-base digit): terminate.
- Accumulate: mag <= mag*base + d, computed at DSZ+6 bits. If the upper bits are nonzero, set ovf (sticky) and keep the low DSZ bits. One digit per cycle.
- Terminate:
  - ea <= ai-1, the terminator's address.
  - err <= 1 if no digit was accumulated; this covers a bare sign or an empty/space-only string.
  - vo <= neg ? -mag : mag, mod 2^DSZ, for ACC termination and also when err is set.
  - Go DONE.
- Counter reaching MAXLEN terminates identically. ea is then the address of the next unscanned character.
- DONE: done=1 and bsy=0 for one cycle, then IDLE. vo, err, ovf and ea hold until the next accepted start.
- Latency: string of S leading spaces, s sign characters (0/1) and N digits gives done exactly S+s+N+2 cycles after the start cycle.
- ovf checks unsigned magnitude only: "-2147483648" at DSZ=32 gives vo=0x80000000 with ovf=0.

Test Plan:
- Base 10, "1234\0" at tib=0x100 -> done 6 cycles after start; vo=1234, err=0, ovf=0, ea=0x104.
- Base 16, "  -fF " -> vo=-255 (0xFFFFFF01), ea=tib+5, done at 7 cycles; mixed case accepted.
- Base 36, "Zz" -> vo=1295. Base 2, "1012" -> vo=5 with ea at the '2'. Base 1 -> done next cycle, err=1.
- Base 10, "4294967296" at DSZ=32 -> ovf=1, vo=0. "-" alone and "   \0" -> err=1, vo=0.
- MAXLEN=8, base 10, "123456789" -> terminates after 8 characters; vo=12345678, ea=tib+8.
- rst_n pulsed low mid-ACC -> all outputs 0 immediately and no done pulse; a subsequent start converts "7" -> vo=7. start asserted while bsy -> ignored, result unchanged.
